// File: rtl/spwtcr_pkg.sv
// Shared SpwTCR definitions: divider width defaults, startup rate and divider packing.
package spwtcr_pkg;

  localparam int DIV_W_DEF       = 8;
  localparam int FRAC_W_DEF      = 4;
  localparam int STARTUP_DIV_DEF = 19;  // 10 Mb/s from a 200 MHz clock

  // Run divider as carried on RATE_DIV at the default widths.
  typedef struct packed {
    logic [DIV_W_DEF-1:0]  int_part;
    logic [FRAC_W_DEF-1:0] frac_part;
  } spw_div_t;

  // Which source paces the next reload; debug visibility only.
  typedef enum logic [1:0] {
    MODE_IDLE    = 2'd0,
    MODE_STARTUP = 2'd1,
    MODE_RUN     = 2'd2,
    MODE_UPDATE  = 2'd3
  } gen_mode_t;

endpackage

// File: rtl/spwtcr_tx_rate_gen_if.sv
// Control/status bundle between the link FSM (master) and the TX rate generator (slave).
interface spwtcr_tx_rate_gen_if
  import spwtcr_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
);
  // Handshake: RATE_REQ is taken only while RATE_BUSY is low; the captured
  // RATE_DIV stays pending (RATE_BUSY high) until a period boundary or ENABLE
  // low, where RATE_ACK pulses once and RATE_BUSY drops in that same cycle.
  logic                    ENABLE;
  logic                    startupRate;
  logic [DIV_W+FRAC_W-1:0] RATE_DIV;
  logic                    RATE_REQ;
  logic                    RATE_BUSY;
  logic                    RATE_ACK;
  logic                    CLK_EN;

  logic [DIV_W-1:0]        dbg_cnt;
  logic [FRAC_W-1:0]       dbg_acc;
  logic [DIV_W+FRAC_W-1:0] dbg_act;
  gen_mode_t               dbg_mode;

  modport master (
    output ENABLE, startupRate, RATE_DIV, RATE_REQ,
    input  RATE_BUSY, RATE_ACK, CLK_EN,
    input  dbg_cnt, dbg_acc, dbg_act, dbg_mode
  );

  modport slave (
    input  ENABLE, startupRate, RATE_DIV, RATE_REQ,
    output RATE_BUSY, RATE_ACK, CLK_EN,
    output dbg_cnt, dbg_acc, dbg_act, dbg_mode
  );

endinterface

// File: rtl/spwtcr_frac_acc.sv
// Fractional phase accumulator: adds the divider fraction once per period and
// reports the carry that stretches that period by one cycle.
module spwtcr_frac_acc #(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add_en,
  input  logic [FRAC_W-1:0] addend,
  output logic [FRAC_W-1:0] acc,
  output logic              carry
);

  logic [FRAC_W:0] sum;

  assign sum   = {1'b0, acc} + {1'b0, addend};
  assign carry = sum[FRAC_W];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/spwtcr_tx_rate_gen.sv
// TX bit-rate enable generator: integer down-counter widened by a fractional
// accumulator, with run-rate updates applied only at period boundaries.
module spwtcr_tx_rate_gen
  import spwtcr_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int FRAC_W      = FRAC_W_DEF,  // must be at least 1
  parameter int STARTUP_DIV = STARTUP_DIV_DEF
) (
  input logic                 CLOCK,
  input logic                 RESET,
  spwtcr_tx_rate_gen_if.slave bus
);

  localparam int                RW          = DIV_W + FRAC_W;
  localparam logic [DIV_W-1:0]  STARTUP_INT = DIV_W'(STARTUP_DIV);
  localparam logic [RW-1:0]     RUN_DIV_RST = {STARTUP_INT, {FRAC_W{1'b0}}};

  logic [DIV_W-1:0]  cnt;
  logic [RW-1:0]     act;
  logic [RW-1:0]     shd;
  logic              pending;
  logic              clk_en;
  logic              rate_ack;

  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [DIV_W-1:0]  shd_int;
  logic [FRAC_W-1:0] acc;
  logic              carry;
  logic              reload;
  logic              acc_clr;
  logic              acc_add;
  logic [DIV_W:0]    run_sum;
  logic [DIV_W-1:0]  next_run_cnt;
  gen_mode_t         mode;

  assign act_int  = act[RW-1:FRAC_W];
  assign act_frac = act[FRAC_W-1:0];
  assign shd_int  = shd[RW-1:FRAC_W];
  assign reload   = bus.ENABLE && (cnt == '0);

  // The accumulator restarts whenever the phase reference changes: disable,
  // startup pacing, or a newly applied run divider.
  assign acc_clr = !bus.ENABLE || (reload && (bus.startupRate || pending));
  assign acc_add = reload && !bus.startupRate && !pending;

  spwtcr_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clk    (CLOCK),
    .rst    (RESET),
    .clr    (acc_clr),
    .add_en (acc_add),
    .addend (act_frac),
    .acc    (acc),
    .carry  (carry)
  );

  // A carry on the largest divider is dropped instead of wrapping to a short period.
  always_comb begin
    run_sum      = {1'b0, act_int} + {{DIV_W{1'b0}}, carry};
    next_run_cnt = run_sum[DIV_W] ? act_int : run_sum[DIV_W-1:0];
  end

  always_comb begin
    mode = MODE_IDLE;
    if (bus.ENABLE) begin
      if (bus.startupRate) begin
        mode = MODE_STARTUP;
      end else if (pending) begin
        mode = MODE_UPDATE;
      end else begin
        mode = MODE_RUN;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt      <= '0;
      act      <= RUN_DIV_RST;
      shd      <= RUN_DIV_RST;
      pending  <= 1'b0;
      clk_en   <= 1'b0;
      rate_ack <= 1'b0;
    end else begin
      clk_en   <= 1'b0;
      rate_ack <= 1'b0;
      if (!bus.ENABLE) begin
        cnt <= '0;
        if (pending) begin
          act      <= shd;
          pending  <= 1'b0;
          rate_ack <= 1'b1;
        end
      end else if (reload) begin
        clk_en <= 1'b1;
        if (bus.startupRate) begin
          cnt <= STARTUP_INT;
        end else if (pending) begin
          act      <= shd;
          cnt      <= shd_int;
          pending  <= 1'b0;
          rate_ack <= 1'b1;
        end else begin
          cnt <= next_run_cnt;
        end
      end else begin
        cnt <= cnt - DIV_W'(1);
      end
      // Capture looks at the old pending flag, so a request in a reload cycle
      // is only applied at the following reload.
      if (bus.RATE_REQ && !pending) begin
        shd     <= bus.RATE_DIV;
        pending <= 1'b1;
      end
    end
  end

  assign bus.CLK_EN    = clk_en;
  assign bus.RATE_ACK  = rate_ack;
  assign bus.RATE_BUSY = pending;
  assign bus.dbg_cnt   = cnt;
  assign bus.dbg_acc   = acc;
  assign bus.dbg_act   = act;
  assign bus.dbg_mode  = mode;

endmodule

// File: tb/tb_spwtcr_tx_rate_gen.sv
// Directed bench for the TX rate generator at DIV_W=8, FRAC_W=4, STARTUP_DIV=19.
module tb_spwtcr_tx_rate_gen;
  import spwtcr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spwtcr_tx_rate_gen_if #(.DIV_W(8), .FRAC_W(4)) bus ();

  spwtcr_tx_rate_gen #(
    .DIV_W       (8),
    .FRAC_W      (4),
    .STARTUP_DIV (19)
  ) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  function automatic spw_div_t mk(input int i, input int f);
    spw_div_t d;
    d.int_part  = 8'(i);
    d.frac_part = 4'(f);
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until CLK_EN is seen; n is the number of edges taken, -1 on timeout.
  task automatic wait_pulse(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget && n < 0; i++) begin
      step();
      if (bus.CLK_EN === 1'b1) n = i;
    end
  endtask

  task automatic request(input spw_div_t d);
    bus.RATE_DIV = d;
    bus.RATE_REQ = 1'b1;
    step();
    bus.RATE_REQ = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ENABLE = 1'b0; bus.startupRate = 1'b1; bus.RATE_REQ = 1'b0; bus.RATE_DIV = '0;
    step(); step();
    checks++; if (bus.CLK_EN !== 1'b0) begin errors++; $display("FAIL rst_clk_en: got %b want 0", bus.CLK_EN); end
    checks++; if (bus.RATE_ACK !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", bus.RATE_ACK); end
    checks++; if (bus.RATE_BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.RATE_BUSY); end
    checks++; if (bus.dbg_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", bus.dbg_cnt); end
    checks++; if (bus.dbg_acc !== 4'd0) begin errors++; $display("FAIL rst_acc: got %0d want 0", bus.dbg_acc); end
    checks++; if (bus.dbg_act !== 12'h130) begin errors++; $display("FAIL rst_act: got %h want 130", bus.dbg_act); end
    rst = 1'b0;
  endtask

  task automatic test_startup();
    int n;
    bus.ENABLE = 1'b1;
    step();
    checks++; if (bus.CLK_EN !== 1'b1) begin errors++; $display("FAIL first_pulse: got %b want 1", bus.CLK_EN); end
    for (int k = 0; k < 3; k++) begin
      wait_pulse(40, n);
      checks++; if (n != 20) begin errors++; $display("FAIL startup_period: got %0d want 20", n); end
    end
    checks++; if (bus.RATE_BUSY !== 1'b0) begin errors++; $display("FAIL startup_busy: got %b want 0", bus.RATE_BUSY); end
  endtask

  task automatic test_frac_rate();
    int n;
    int total;
    bus.startupRate = 1'b0;
    request(mk(3, 8));
    checks++; if (bus.RATE_BUSY !== 1'b1) begin errors++; $display("FAIL frac_busy: got %b want 1", bus.RATE_BUSY); end
    wait_pulse(40, n);
    checks++; if (bus.RATE_ACK !== 1'b1) begin errors++; $display("FAIL frac_ack: got %b want 1", bus.RATE_ACK); end
    checks++; if (bus.RATE_BUSY !== 1'b0) begin errors++; $display("FAIL frac_busy_fall: got %b want 0", bus.RATE_BUSY); end
    checks++; if (bus.dbg_act !== 12'h038) begin errors++; $display("FAIL frac_act: got %h want 038", bus.dbg_act); end
    wait_pulse(10, n);
    checks++; if (n != 4) begin errors++; $display("FAIL frac_first_period: got %0d want 4", n); end
    total = 0;
    for (int i = 0; i < 16; i++) begin
      wait_pulse(10, n);
      checks++; if (n != ((i % 2 == 0) ? 4 : 5)) begin errors++; $display("FAIL frac_period_%0d: got %0d want %0d", i, n, (i % 2 == 0) ? 4 : 5); end
      total += n;
    end
    checks++; if (total != 72) begin errors++; $display("FAIL frac_span16: got %0d want 72", total); end
  endtask

  task automatic test_midperiod_req();
    int n;
    request(mk(3, 0));
    wait_pulse(10, n);
    checks++; if (bus.RATE_ACK !== 1'b1) begin errors++; $display("FAIL mid_setup_ack: got %b want 1", bus.RATE_ACK); end
    for (int k = 0; k < 2; k++) begin
      wait_pulse(10, n);
      checks++; if (n != 4) begin errors++; $display("FAIL mid_int3_period: got %0d want 4", n); end
    end
    request(mk(9, 0));
    checks++; if (bus.RATE_BUSY !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", bus.RATE_BUSY); end
    request(mk(5, 0));
    checks++; if (bus.RATE_BUSY !== 1'b1) begin errors++; $display("FAIL mid_busy_hold: got %b want 1", bus.RATE_BUSY); end
    wait_pulse(10, n);
    checks++; if (n != 2) begin errors++; $display("FAIL mid_period_rest: got %0d want 2", n); end
    checks++; if (bus.RATE_ACK !== 1'b1) begin errors++; $display("FAIL mid_ack: got %b want 1", bus.RATE_ACK); end
    checks++; if (bus.dbg_act !== 12'h090) begin errors++; $display("FAIL mid_act: got %h want 090", bus.dbg_act); end
    for (int k = 0; k < 2; k++) begin
      wait_pulse(20, n);
      checks++; if (n != 10) begin errors++; $display("FAIL mid_int9_period: got %0d want 10", n); end
      checks++; if (bus.RATE_ACK !== 1'b0) begin errors++; $display("FAIL mid_no_second_ack: got %b want 0", bus.RATE_ACK); end
    end
    checks++; if (bus.RATE_BUSY !== 1'b0) begin errors++; $display("FAIL mid_ignored_req: got %b want 0", bus.RATE_BUSY); end
  endtask

  task automatic test_disable_pending();
    int n;
    request(mk(2, 0));
    checks++; if (bus.RATE_BUSY !== 1'b1) begin errors++; $display("FAIL dis_busy: got %b want 1", bus.RATE_BUSY); end
    bus.ENABLE = 1'b0;
    step();
    checks++; if (bus.RATE_ACK !== 1'b1) begin errors++; $display("FAIL dis_ack: got %b want 1", bus.RATE_ACK); end
    checks++; if (bus.CLK_EN !== 1'b0) begin errors++; $display("FAIL dis_clk_en: got %b want 0", bus.CLK_EN); end
    checks++; if (bus.RATE_BUSY !== 1'b0) begin errors++; $display("FAIL dis_busy_fall: got %b want 0", bus.RATE_BUSY); end
    checks++; if (bus.dbg_cnt !== 8'd0) begin errors++; $display("FAIL dis_cnt: got %0d want 0", bus.dbg_cnt); end
    step();
    checks++; if (bus.RATE_ACK !== 1'b0) begin errors++; $display("FAIL dis_ack_once: got %b want 0", bus.RATE_ACK); end
    checks++; if (bus.CLK_EN !== 1'b0) begin errors++; $display("FAIL dis_clk_en_idle: got %b want 0", bus.CLK_EN); end
    checks++; if (bus.dbg_act !== 12'h020) begin errors++; $display("FAIL dis_act: got %h want 020", bus.dbg_act); end
    bus.ENABLE = 1'b1;
    step();
    checks++; if (bus.CLK_EN !== 1'b1) begin errors++; $display("FAIL en_first_pulse: got %b want 1", bus.CLK_EN); end
    wait_pulse(10, n);
    checks++; if (n != 3) begin errors++; $display("FAIL en_new_period: got %0d want 3", n); end
  endtask

  task automatic test_reset_midperiod();
    int n;
    request(mk(9, 0));
    wait_pulse(20, n);
    checks++; if (bus.RATE_ACK !== 1'b1) begin errors++; $display("FAIL rm_setup_ack: got %b want 1", bus.RATE_ACK); end
    request(mk(1, 0));
    step(); step(); step();
    checks++; if (bus.dbg_cnt !== 8'd5) begin errors++; $display("FAIL rm_cnt: got %0d want 5", bus.dbg_cnt); end
    checks++; if (bus.RATE_BUSY !== 1'b1) begin errors++; $display("FAIL rm_busy: got %b want 1", bus.RATE_BUSY); end
    rst = 1'b1;
    step();
    checks++; if (bus.CLK_EN !== 1'b0) begin errors++; $display("FAIL rm_clk_en: got %b want 0", bus.CLK_EN); end
    checks++; if (bus.RATE_ACK !== 1'b0) begin errors++; $display("FAIL rm_ack: got %b want 0", bus.RATE_ACK); end
    checks++; if (bus.RATE_BUSY !== 1'b0) begin errors++; $display("FAIL rm_busy_clr: got %b want 0", bus.RATE_BUSY); end
    checks++; if (bus.dbg_cnt !== 8'd0) begin errors++; $display("FAIL rm_cnt_clr: got %0d want 0", bus.dbg_cnt); end
    checks++; if (bus.dbg_act !== 12'h130) begin errors++; $display("FAIL rm_act: got %h want 130", bus.dbg_act); end
    rst = 1'b0;
    step();
    checks++; if (bus.CLK_EN !== 1'b1) begin errors++; $display("FAIL rm_restart_pulse: got %b want 1", bus.CLK_EN); end
    checks++; if (bus.RATE_ACK !== 1'b0) begin errors++; $display("FAIL rm_lost_req: got %b want 0", bus.RATE_ACK); end
    wait_pulse(30, n);
    checks++; if (n != 20) begin errors++; $display("FAIL rm_rst_rate: got %0d want 20", n); end
  endtask

  task automatic test_div_zero();
    int n;
    request(mk(0, 0));
    wait_pulse(30, n);
    checks++; if (n != 19) begin errors++; $display("FAIL z_last_period: got %0d want 19", n); end
    checks++; if (bus.RATE_ACK !== 1'b1) begin errors++; $display("FAIL z_ack: got %b want 1", bus.RATE_ACK); end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (bus.CLK_EN !== 1'b1) begin errors++; $display("FAIL z_continuous_%0d: got %b want 1", i, bus.CLK_EN); end
    end
  endtask

  task automatic test_max_div();
    int n;
    request(mk(255, 15));
    checks++; if (bus.CLK_EN !== 1'b1) begin errors++; $display("FAIL max_reload_req_pulse: got %b want 1", bus.CLK_EN); end
    checks++; if (bus.RATE_ACK !== 1'b0) begin errors++; $display("FAIL max_reload_req_defer: got %b want 0", bus.RATE_ACK); end
    step();
    checks++; if (bus.CLK_EN !== 1'b1) begin errors++; $display("FAIL max_apply_pulse: got %b want 1", bus.CLK_EN); end
    checks++; if (bus.RATE_ACK !== 1'b1) begin errors++; $display("FAIL max_apply_ack: got %b want 1", bus.RATE_ACK); end
    for (int k = 0; k < 4; k++) begin
      wait_pulse(300, n);
      checks++; if (n != 256) begin errors++; $display("FAIL max_period_%0d: got %0d want 256", k, n); end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_frac_rate();
    test_midperiod_req();
    test_disable_pending();
    test_reset_midperiod();
    test_div_zero();
    test_max_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
